wb_stream_reader: RTL
=====================

Name: wb_stream_reader

Overview:
- Stream-to-memory DMA engine: the inverse of the stream writer path.
- Accepts a valid/ready data stream into an internal FIFO and writes it to a memory buffer as Wishbone master incrementing bursts.
- Driven by a config block's enable pulse, start_adr, buf_size and burst_size.
- Signals completion to software with a one-cycle done pulse.

Parameters:
WB_AW, 32, Wishbone address width (byte addresses)
WB_DW, 32, Wishbone/stream data width; word = WB_DW/8 bytes
FIFO_AW, 4, log2 of internal FIFO depth in words (depth 16)

Ports:
wb_clk_i  in  1  clock, all logic on rising edge
wb_rst_n_i  in  1  asynchronous active-low reset
enable  in  1  one-cycle start pulse
start_adr  in  WB_AW  buffer byte base address, word aligned
buf_size  in  WB_AW  buffer length in words
burst_size  in  WB_AW  max words per burst
stream_data  in  WB_DW  input stream data
stream_valid  in  1  input stream valid
stream_ready  out  1  input stream ready
wbm_adr_o  out  WB_AW  master byte address
wbm_dat_o  out  WB_DW  master write data (FIFO head)
wbm_sel_o  out  WB_DW/8  byte selects, all ones
wbm_we_o  out  1  write enable
wbm_cyc_o  out  1  cycle
wbm_stb_o  out  1  strobe
wbm_cti_o  out  3  cycle type
wbm_bte_o  out  2  burst type, constant 2'b00
wbm_ack_i  in  1  slave ack
wbm_err_i  in  1  slave error
busy  out  1  transfer in progress
done  out  1  one-cycle pulse, buffer completed
error  out  1  one-cycle pulse, transfer aborted by wbm_err_i

Behaviour:
- Reset (async assert, sync deassert assumed by system): state IDLE, FIFO empty, all wbm_* strobes/cyc 0, wbm_adr_o 0, wbm_cti_o 0, busy/done/error 0, stream_ready 0 until first clock after release.
- Stream side: stream_ready = !fifo_full in every state. A word is pushed on stream_valid & stream_ready. Data arriving before enable is buffered, not dropped.
- FIFO: 2^FIFO_AW words, FWFT; wbm_dat_o = head. Simultaneous push and pop is allowed when full (pop frees space same cycle only for the next cycle; ready stays 0 that cycle).
- State IDLE:
  - On enable, latch adr = start_adr and remaining = buf_size.
  - If buf_size == 0, pulse done next cycle and stay IDLE.
  - Otherwise go to WAIT with busy = 1.
  - enable while busy is ignored.
- State WAIT:
  - blen = min(max(burst_size,1), remaining, 2^FIFO_AW).
  - Go to BURST when fifo_level >= blen, with beat counter = blen.
- State BURST:
  - wbm_cyc_o = wbm_stb_o = wbm_we_o = 1, wbm_adr_o = adr.
  - wbm_cti_o = 3'b010 for non-final beats and 3'b111 on the final beat; a single-beat burst uses 3'b111.
  - Each cycle with wbm_ack_i: pop FIFO, adr += WB_DW/8, remaining -= 1, beat counter -= 1.
  - On the final-beat ack, drop cyc/stb the next cycle (registered). Go to WAIT if remaining != 0; otherwise go to IDLE, pulse done, and clear busy.
  - stb is held until ack; no wait states are inserted by the master between beats.
- wbm_err_i during BURST: the beat is not popped. Drop cyc/stb next cycle, pulse error, go IDLE, busy = 0. FIFO contents are retained.
- Address arithmetic: WB_AW wide, wraps modulo 2^WB_AW with no fault.
- Config inputs are sampled only on enable; later changes have no effect mid-transfer.
- Reset mid-burst: immediate cyc/stb deassert, FIFO flushed.

Test Plan:
- Basic transfer: start_adr=0x1000, buf_size=8, burst_size=4, stream 0x0..0x7 → two 4-beat bursts to 0x1000 and 0x1010, cti 010,010,010,111 each; mem[0x1000..0x101C] = 0..7; one done pulse; busy low after.
- Short tail burst: buf_size=5, burst_size=4 → burst of 4 then 1 beat at 0x1010 with cti=111.
- Burst clamping: burst_size=0 → single-beat bursts. burst_size=64 with FIFO_AW=4 → bursts of 16 beats.
- Backpressure and stalls: random stream_valid gaps and ack wait states, buf_size=40 → no data loss or duplication; stream_ready low exactly while FIFO holds 16 words.
- Zero-size start and ignored enable: buf_size=0 → done pulse with no wbm_cyc_o. A second enable during a transfer is ignored.
- Error and reset recovery: assert wbm_err_i on beat 2 → error pulse, cyc drops, busy=0, FIFO level unchanged. Then assert wb_rst_n_i low mid-burst → cyc/stb 0 immediately, FIFO empty.

Source files
------------

// File: rtl/wb_stream_reader.sv
// Stream-to-memory DMA: buffers a valid/ready stream in a FWFT FIFO and
// writes it out as Wishbone incrementing bursts into a memory buffer.
module wb_stream_reader #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  input  logic [WB_DW-1:0]     stream_data,
  input  logic                 stream_valid,
  output logic                 stream_ready,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [WB_AW-1:0] DEPTH_W  = WB_AW'(DEPTH);
  localparam logic [WB_AW-1:0] ONE_W    = WB_AW'(1);
  localparam logic [WB_AW-1:0] STEP_W   = WB_AW'(WB_DW / 8);
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  state_t state, state_nxt;

  logic [WB_DW-1:0]   fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               fifo_full;
  logic               ready_en;
  logic               push, pop;

  logic [WB_AW-1:0]   adr;
  logic [WB_AW-1:0]   remaining;
  logic [WB_AW-1:0]   burst_cfg;
  logic [WB_AW-1:0]   beats;
  logic [WB_AW-1:0]   blen;
  logic [WB_AW-1:0]   level_w;
  logic               burst_go;
  logic               last_ack;

  // ---------------------------------------------------------------- FIFO
  assign fifo_full    = (level == FULL_LVL);
  assign stream_ready = ready_en & ~fifo_full;
  assign push         = stream_valid & stream_ready;
  assign pop          = (state == BURST) & wbm_ack_i & ~wbm_err_i;
  assign level_w      = WB_AW'(level);

  // Holds stream_ready low through reset and the first clock after release.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) ready_en <= 1'b0;
    else             ready_en <= 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= stream_data;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ------------------------------------------------------- burst sizing
  always_comb begin
    blen = (burst_cfg == '0) ? ONE_W : burst_cfg;
    if (remaining < blen) blen = remaining;
    if (blen > DEPTH_W)   blen = DEPTH_W;
  end

  assign burst_go = (state == WAIT) && (level_w >= blen);
  assign last_ack = pop && (beats == ONE_W);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable && (buf_size != '0)) state_nxt = WAIT;
      WAIT:  if (burst_go) state_nxt = BURST;
      BURST: begin
        if (wbm_err_i)     state_nxt = IDLE;
        else if (last_ack) state_nxt = (remaining == ONE_W) ? IDLE : WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o = (state == BURST);
    wbm_stb_o = (state == BURST);
    wbm_we_o  = (state == BURST);
    wbm_cti_o = 3'b000;
    if (state == BURST) wbm_cti_o = (beats == ONE_W) ? 3'b111 : 3'b010;
    wbm_adr_o = adr;
    wbm_dat_o = fifo_mem[rd_ptr];
    wbm_sel_o = '1;
    wbm_bte_o = 2'b00;
    busy      = (state != IDLE);
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      adr       <= '0;
      remaining <= '0;
      burst_cfg <= '0;
      beats     <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if ((state == IDLE) && enable) begin
        adr       <= start_adr;
        remaining <= buf_size;
        burst_cfg <= burst_size;
        if (buf_size == '0) done <= 1'b1;
      end
      if (burst_go) beats <= blen;
      if ((state == BURST) && wbm_err_i) error <= 1'b1;
      if (pop) begin
        adr       <= adr + STEP_W;
        remaining <= remaining - ONE_W;
        beats     <= beats - ONE_W;
        if (last_ack && (remaining == ONE_W)) done <= 1'b1;
      end
    end
  end

endmodule
